// File: rtl/bin2bcd_seq_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
//   bcd_digit_t    : one packed BCD digit
//   b2b_state_t    : converter FSM states
//   BCD_ADJ_THRESH : a digit at or above this value is corrected before the shift
//   BCD_ADJ        : the correction added to such a digit
package bin2bcd_seq_pkg;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } b2b_state_t;

    localparam bcd_digit_t BCD_ADJ_THRESH = 4'd5;
    localparam bcd_digit_t BCD_ADJ        = 4'd3;

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Handshake bundle between a binary producer and the BCD converter.
//   in_valid/in_ready/bin         : operand handshake (producer -> converter)
//   out_valid/out_ready/bcd/ovf   : result handshake (converter -> consumer)
// Modports: master = producer/consumer side (the bench), slave = the converter.
interface bin2bcd_seq_if #(
    parameter int W  = 8,
    parameter int ND = 3
);
    logic            in_valid;
    logic            in_ready;
    logic [W-1:0]    bin;
    logic            out_valid;
    logic            out_ready;
    logic [4*ND-1:0] bcd;
    logic            ovf;

    modport master (
        output in_valid, bin, out_ready,
        input  in_ready, out_valid, bcd, ovf
    );

    modport slave (
        input  in_valid, bin, out_ready,
        output in_ready, out_valid, bcd, ovf
    );
endinterface

// File: rtl/bin2bcd_seq_dabble_digit.sv
// Combinational add-3 correction for one BCD digit of the double-dabble loop.
//   d : digit value before the shift
//   q : d + 3 when d >= 5, else d (never exceeds 12, so no carry out)
module bin2bcd_seq_dabble_digit
    import bin2bcd_seq_pkg::*;
(
    input  bcd_digit_t d,
    output bcd_digit_t q
);
    always_comb begin
        q = d;
        if (d >= BCD_ADJ_THRESH) begin
            q = d + BCD_ADJ;
        end
    end
endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3), one input bit per clock.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset, returns to IDLE immediately
//   bus   : bin2bcd_seq_if slave - operand and result valid/ready handshakes
// Parameters: W binary width, ND number of BCD digits produced.
//
// state | meaning
// IDLE  | waiting for an operand, in_ready high
// SHIFT | W adjust+shift steps in progress
// DONE  | result held with out_valid high until the consumer takes it
module bin2bcd_seq
    import bin2bcd_seq_pkg::*;
#(
    parameter int W  = 8,
    parameter int ND = 3
) (
    input  logic          clk,
    input  logic          reset,
    bin2bcd_seq_if.slave  bus
);
    localparam int CW = $clog2(W + 1);
    localparam int BW = 4 * ND;

    b2b_state_t    state, state_nx;
    logic [W-1:0]  bin_sh;
    logic [BW-1:0] bcd_r;
    logic [BW-1:0] bcd_adj;
    logic          ovf_r;
    logic [CW-1:0] cnt;
    logic          accept;
    logic          last_shift;

    // All digits are corrected in parallel from the current register value.
    for (genvar i = 0; i < ND; i++) begin : g_dig
        bin2bcd_seq_dabble_digit u_dig (
            .d (bcd_r[4*i +: 4]),
            .q (bcd_adj[4*i +: 4])
        );
    end

    // in_ready is gated by reset so nothing is accepted while reset is held.
    assign bus.in_ready  = (state == IDLE) && !reset;
    assign bus.out_valid = (state == DONE);
    assign bus.bcd       = bcd_r;
    assign bus.ovf       = ovf_r;

    assign accept     = bus.in_valid && bus.in_ready;
    assign last_shift = (cnt == CW'(1));

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = SHIFT;
            SHIFT:   if (last_shift) state_nx = DONE;
            DONE:    if (bus.out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            bin_sh <= '0;
            bcd_r  <= '0;
            ovf_r  <= 1'b0;
            cnt    <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && accept) begin
                bin_sh <= bus.bin;
                bcd_r  <= '0;
                ovf_r  <= 1'b0;
                cnt    <= CW'(W);
            end else if (state == SHIFT) begin
                // The top adjusted bit leaves the digit field; any 1 there means
                // the value no longer fits in ND digits.
                bcd_r  <= {bcd_adj[BW-2:0], bin_sh[W-1]};
                bin_sh <= bin_sh << 1;
                ovf_r  <= ovf_r | bcd_adj[BW-1];
                cnt    <= cnt - CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed self-checking bench for bin2bcd_seq: a 3-digit instance for the main
// checks and a 2-digit instance for the overflow cases.
module tb_bin2bcd_seq;
    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    bin2bcd_seq_if #(.W(8), .ND(3)) if3 ();
    bin2bcd_seq_if #(.W(8), .ND(2)) if2 ();

    bin2bcd_seq #(.W(8), .ND(3)) dut3 (.clk(clk), .reset(reset), .bus(if3.slave));
    bin2bcd_seq #(.W(8), .ND(2)) dut2 (.clk(clk), .reset(reset), .bus(if2.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Present v on the 3-digit instance, wait for acceptance, then count edges
    // until out_valid (bounded).
    task automatic start3(input logic [7:0] v, output int lat);
        int n;
        n = 0;
        @(negedge clk);
        if3.in_valid = 1'b1;
        if3.bin      = v;
        while (!if3.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        if3.in_valid = 1'b0;
        if3.bin      = 8'hA5;
        lat = 0;
        while (!if3.out_valid && lat < 40) begin
            @(posedge clk);
            lat++;
            #1;
        end
    endtask

    task automatic release3();
        @(negedge clk);
        if3.out_ready = 1'b1;
        @(posedge clk);
        #1;
        if3.out_ready = 1'b0;
    endtask

    task automatic start2(input logic [7:0] v, output int lat);
        int n;
        n = 0;
        @(negedge clk);
        if2.in_valid = 1'b1;
        if2.bin      = v;
        while (!if2.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        if2.in_valid = 1'b0;
        if2.bin      = 8'h5A;
        lat = 0;
        while (!if2.out_valid && lat < 40) begin
            @(posedge clk);
            lat++;
            #1;
        end
    endtask

    task automatic release2();
        @(negedge clk);
        if2.out_ready = 1'b1;
        @(posedge clk);
        #1;
        if2.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #3;
        n_tests++;
        if (if3.in_ready !== 1'b0 || if2.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_in_ready got %b/%b exp 0/0", if3.in_ready, if2.in_ready);
        end
        n_tests++;
        if (if3.out_valid !== 1'b0 || if3.bcd !== 12'h000 || if3.ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs got ov=%b bcd=%h ovf=%b exp 0/000/0",
                     if3.out_valid, if3.bcd, if3.ovf);
        end
        n_tests++;
        if (if2.out_valid !== 1'b0 || if2.bcd !== 8'h00 || if2.ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs2 got ov=%b bcd=%h ovf=%b exp 0/00/0",
                     if2.out_valid, if2.bcd, if2.ovf);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_tests++;
        if (if3.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL release_in_ready got %b exp 1", if3.in_ready);
        end
    endtask

    task automatic test_convert();
        logic [7:0]  vals [7] = '{8'd0, 8'd255, 8'd99, 8'd100, 8'd37, 8'd9, 8'd10};
        logic [11:0] exps [7] = '{12'h000, 12'h255, 12'h099, 12'h100, 12'h037, 12'h009, 12'h010};
        int lat;
        for (int i = 0; i < 7; i++) begin
            start3(vals[i], lat);
            n_tests++;
            if (lat !== 8) begin
                n_fail++;
                $display("FAIL conv_latency v=%0d got %0d exp 8", vals[i], lat);
            end
            n_tests++;
            if (if3.bcd !== exps[i] || if3.ovf !== 1'b0) begin
                n_fail++;
                $display("FAIL conv_result v=%0d got bcd=%h ovf=%b exp bcd=%h ovf=0",
                         vals[i], if3.bcd, if3.ovf, exps[i]);
            end
            release3();
            n_tests++;
            if (if3.in_ready !== 1'b1 || if3.out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL conv_return_idle got rdy=%b ov=%b exp 1/0",
                         if3.in_ready, if3.out_valid);
            end
        end
    endtask

    task automatic test_overflow();
        logic [7:0] vals [4] = '{8'd100, 8'd99, 8'd255, 8'd9};
        logic [7:0] exps [4] = '{8'h00, 8'h99, 8'h55, 8'h09};
        logic       ovfs [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        int lat;
        for (int i = 0; i < 4; i++) begin
            start2(vals[i], lat);
            n_tests++;
            if (lat !== 8 || if2.bcd !== exps[i] || if2.ovf !== ovfs[i]) begin
                n_fail++;
                $display("FAIL ovf_result v=%0d got lat=%0d bcd=%h ovf=%b exp lat=8 bcd=%h ovf=%b",
                         vals[i], lat, if2.bcd, if2.ovf, exps[i], ovfs[i]);
            end
            release2();
        end
    endtask

    task automatic test_stall();
        int lat;
        start3(8'd123, lat);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if3.in_valid = 1'b1;
            if3.bin      = 8'd7;
            n_tests++;
            if (if3.out_valid !== 1'b1 || if3.bcd !== 12'h123 || if3.ovf !== 1'b0 ||
                if3.in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_hold cyc=%0d got ov=%b bcd=%h ovf=%b rdy=%b exp 1/123/0/0",
                         i, if3.out_valid, if3.bcd, if3.ovf, if3.in_ready);
            end
        end
        if3.in_valid = 1'b0;
        release3();
        n_tests++;
        if (if3.in_ready !== 1'b1 || if3.out_valid !== 1'b0 || if3.bcd !== 12'h123) begin
            n_fail++;
            $display("FAIL stall_release got rdy=%b ov=%b bcd=%h exp 1/0/123",
                     if3.in_ready, if3.out_valid, if3.bcd);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        int bad;
        @(negedge clk);
        if3.in_valid = 1'b1;
        if3.bin      = 8'd200;
        @(posedge clk);
        #1;
        if3.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        n_tests++;
        if (if3.out_valid !== 1'b0 || if3.bcd !== 12'h000 || if3.ovf !== 1'b0 ||
            if3.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_clear got ov=%b bcd=%h ovf=%b rdy=%b exp 0/000/0/0",
                     if3.out_valid, if3.bcd, if3.ovf, if3.in_ready);
        end
        @(negedge clk);
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (if3.out_valid !== 1'b0) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL midreset_no_pulse got %0d cycles with out_valid exp 0", bad);
        end
        start3(8'd37, lat);
        n_tests++;
        if (lat !== 8 || if3.bcd !== 12'h037 || if3.ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_next got lat=%0d bcd=%h ovf=%b exp 8/037/0",
                     lat, if3.bcd, if3.ovf);
        end
        release3();
    endtask

    task automatic test_back_to_back();
        int lat;
        int v;
        logic [11:0] exp_bcd;
        for (v = 0; v < 256; v++) begin
            exp_bcd = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
            start3(8'(v), lat);
            n_tests++;
            if (lat !== 8 || if3.bcd !== exp_bcd || if3.ovf !== 1'b0) begin
                n_fail++;
                $display("FAIL sweep v=%0d got lat=%0d bcd=%h ovf=%b exp 8/%h/0",
                         v, lat, if3.bcd, if3.ovf, exp_bcd);
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            release3();
        end
    endtask

    initial begin
        n_tests       = 0;
        n_fail        = 0;
        if3.in_valid  = 1'b0;
        if3.bin       = '0;
        if3.out_ready = 1'b0;
        if2.in_valid  = 1'b0;
        if2.bin       = '0;
        if2.out_ready = 1'b0;
        test_reset();
        test_convert();
        test_overflow();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
